dm_sba_arbiter: RTL and testbench

Round-robin arbiter that shares one system-bus access port (the req/gnt/valid port feeding the debug module's AXI adapter) between `NrPorts` requesters, e.g. the SBA engine and the abstract-command memory-access path. The arbiter keeps at most one transaction outstanding. It selects a winner, forwards that winner's payload downstream until the grant, then routes the response back to the owner only. It sits between the requesters and the single `axi_adapter` instance.

---
 rtl/dm_sba_arbiter_if.sv | 42 ++++
 rtl/dm_sba_arbiter.sv | 146 ++++++++++++++
 tb/tb_dm_sba_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_sba_arbiter_if.sv
// rtl/dm_sba_arbiter_if.sv - requester and downstream bus bundle for the SBA arbiter
interface dm_sba_arbiter_if #(
   parameter int unsigned NrPorts = 2
);
   // Requester side
   logic [NrPorts-1:0]       req_i;
   logic [NrPorts-1:0][63:0] addr_i;
   logic [NrPorts-1:0]       we_i;
   logic [NrPorts-1:0][63:0] wdata_i;
   logic [NrPorts-1:0][7:0]  be_i;
   logic [NrPorts-1:0][1:0]  size_i;
   logic [NrPorts-1:0]       gnt_o;
   logic [NrPorts-1:0]       valid_o;
   logic [63:0]              rdata_o;

   // Downstream side towards the AXI adapter
   logic        req_o;
   logic [63:0] addr_o;
   logic        we_o;
   logic [63:0] wdata_o;
   logic [7:0]  be_o;
   logic [1:0]  size_o;
   logic        gnt_i;
   logic        valid_i;
   logic [63:0] rdata_i;

   // Requesters plus the downstream responder
   modport master (
      output req_i, addr_i, we_i, wdata_i, be_i, size_i,
      output gnt_i, valid_i, rdata_i,
      input  gnt_o, valid_o, rdata_o,
      input  req_o, addr_o, we_o, wdata_o, be_o, size_o
   );

   // The arbiter itself
   modport slave (
      input  req_i, addr_i, we_i, wdata_i, be_i, size_i,
      input  gnt_i, valid_i, rdata_i,
      output gnt_o, valid_o, rdata_o,
      output req_o, addr_o, we_o, wdata_o, be_o, size_o
   );
endinterface

// File: rtl/dm_sba_arbiter.sv
// rtl/dm_sba_arbiter.sv - round-robin arbiter sharing one system-bus port, one transaction in flight
module dm_sba_arbiter #(
   parameter int unsigned NrPorts = 2,
   parameter int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            dmactive_i,
   output logic            busy_o,
   dm_sba_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Req  = 2'd1,
      Wait = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] rr_q, rr_d;

   logic            owner_req;
   logic [63:0]     sel_addr;
   logic            sel_we;
   logic [63:0]     sel_wdata;
   logic [7:0]      sel_be;
   logic [1:0]      sel_size;
   logic            win_found;
   logic [IdxW-1:0] win_idx;
   logic [IdxW-1:0] owner_inc;
   int unsigned     cand;

   // Pick out the current owner's request line and payload
   always_comb begin
      owner_req = 1'b0;
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_size  = '0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         if (owner_q == IdxW'(i)) begin
            owner_req = bus.req_i[i];
            sel_addr  = bus.addr_i[i];
            sel_we    = bus.we_i[i];
            sel_wdata = bus.wdata_i[i];
            sel_be    = bus.be_i[i];
            sel_size  = bus.size_i[i];
         end
      end
   end

   // Winner is the first requesting port at or above rr_q, wrapping around
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned k = 0; k < NrPorts; k++) begin
         cand = (32'(rr_q) + k) % NrPorts;
         for (int unsigned i = 0; i < NrPorts; i++) begin
            if (!win_found && cand == i && bus.req_i[i]) begin
               win_found = 1'b1;
               win_idx   = IdxW'(i);
            end
         end
      end
   end

   assign owner_inc = (owner_q == IdxW'(NrPorts - 1)) ? '0 : owner_q + IdxW'(1);

   // Next state; the pointer only moves past a port once that port got its grant
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      unique case (state_q)
         Idle: begin
            if (dmactive_i && win_found) begin
               owner_d = win_idx;
               state_d = Req;
            end
         end
         Req: begin
            if (!dmactive_i || !owner_req) begin
               state_d = Idle;
            end else if (bus.gnt_i) begin
               rr_d    = owner_inc;
               state_d = Wait;
            end
         end
         Wait: begin
            // The in-flight response is always absorbed, even while flushing
            if (bus.valid_i) begin
               state_d = Idle;
            end
         end
         default: state_d = Idle;
      endcase
   end

   // Output decode: grant and response are steered to the owner only
   always_comb begin
      busy_o      = (state_q != Idle);
      bus.req_o   = 1'b0;
      bus.addr_o  = '0;
      bus.we_o    = 1'b0;
      bus.wdata_o = '0;
      bus.be_o    = '0;
      bus.size_o  = '0;
      bus.gnt_o   = '0;
      bus.valid_o = '0;
      bus.rdata_o = '0;
      if (state_q == Req) begin
         bus.req_o   = dmactive_i & owner_req;
         bus.addr_o  = sel_addr;
         bus.we_o    = sel_we;
         bus.wdata_o = sel_wdata;
         bus.be_o    = sel_be;
         bus.size_o  = sel_size;
         for (int unsigned i = 0; i < NrPorts; i++) begin
            bus.gnt_o[i] = (owner_q == IdxW'(i)) & dmactive_i & owner_req & bus.gnt_i;
         end
      end
      if (state_q == Wait && bus.valid_i && dmactive_i) begin
         bus.rdata_o = bus.rdata_i;
         for (int unsigned i = 0; i < NrPorts; i++) begin
            bus.valid_o[i] = (owner_q == IdxW'(i));
         end
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         owner_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
      end
   end

endmodule

// File: tb/tb_dm_sba_arbiter.sv
// tb/tb_dm_sba_arbiter.sv - self-checking bench for dm_sba_arbiter with three requesters
module tb_dm_sba_arbiter;

   localparam int N = 3;
   localparam logic [63:0] RD1 = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] RD2 = 64'h0BAD_F00D_CAFE_0002;
   localparam logic [63:0] RD3 = 64'h1234_5678_9ABC_DEF0;

   logic clk = 1'b0;
   logic rst_n;
   logic dm;
   logic busy;

   logic [63:0] p_addr  [N];
   logic        p_we    [N];
   logic [63:0] p_wdata [N];
   logic [7:0]  p_be    [N];
   logic [1:0]  p_size  [N];

   int n_tests = 0;
   int n_fail  = 0;

   dm_sba_arbiter_if #(.NrPorts(N)) bus ();

   dm_sba_arbiter #(.NrPorts(N)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .dmactive_i (dm),
      .busy_o     (busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         bus.addr_i[k]  = p_addr[k];
         bus.we_i[k]    = p_we[k];
         bus.wdata_i[k] = p_wdata[k];
         bus.be_i[k]    = p_be[k];
         bus.size_i[k]  = p_size[k];
      end
   end

   typedef struct {
      logic        rst;
      logic        dm;
      logic [2:0]  req;
      logic        gnt;
      logic        vld;
      logic [63:0] rdata;
      logic        e_req;
      logic [2:0]  e_gnt;
      logic [2:0]  e_vld;
      logic        e_busy;
      int          e_port;
      logic [63:0] e_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic d, input logic [2:0] req,
                               input logic gnt, input logic vld, input logic [63:0] rd,
                               input logic ereq, input logic [2:0] egnt, input logic [2:0] evld,
                               input logic ebusy, input int eport, input logic [63:0] erd);
      vec_t v;
      v.rst = rst; v.dm = d; v.req = req; v.gnt = gnt; v.vld = vld; v.rdata = rd;
      v.e_req = ereq; v.e_gnt = egnt; v.e_vld = evld; v.e_busy = ebusy;
      v.e_port = eport; v.e_rdata = erd;
      vecs.push_back(v);
   endfunction

   function automatic logic [138:0] pay(input int p);
      if (p < 0) return '0;
      return {p_addr[p], p_we[p], p_wdata[p], p_be[p], p_size[p]};
   endfunction

   function automatic logic [210:0] obs();
      return {bus.req_o, bus.gnt_o, bus.valid_o, busy,
              bus.addr_o, bus.we_o, bus.wdata_o, bus.be_o, bus.size_o, bus.rdata_o};
   endfunction

   task automatic check(input string name, input logic [210:0] act, input logic [210:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      dm = 1'b1;
      bus.req_i = '0; bus.gnt_i = 1'b0; bus.valid_i = 1'b0; bus.rdata_i = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model state: owner -1 means nobody holds the port
   int       m_owner;
   bit       m_wait;
   int       m_rr;
   logic [2:0] last_gnt;
   int       order[$];

   initial begin
      rst_n = 1'b0;
      dm = 1'b1;
      bus.req_i = '0; bus.gnt_i = 1'b0; bus.valid_i = 1'b0; bus.rdata_i = '0;
      for (int k = 0; k < N; k++) begin
         p_addr[k]  = 64'h8000_0000 + 64'(k) * 64'h1000;
         p_we[k]    = (k == 1);
         p_wdata[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
         p_be[k]    = 8'hFF >> k;
         p_size[k]  = 2'(3 - k);
      end

      // reset state
      add(1,1,3'b000,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(1,1,3'b001,1,1,RD1,   0,3'b000,3'b000,0,-1,0);
      // single read on port 0
      add(0,1,3'b001,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b001,0,0,0,     1,3'b000,3'b000,1, 0,0);
      add(0,1,3'b001,1,0,0,     1,3'b001,3'b000,1, 0,0);
      add(0,1,3'b000,0,0,0,     0,3'b000,3'b000,1,-1,0);
      add(0,1,3'b000,0,0,0,     0,3'b000,3'b000,1,-1,0);
      add(0,1,3'b000,0,1,RD1,   0,3'b000,3'b001,1,-1,RD1);
      add(0,1,3'b000,1,1,RD1,   0,3'b000,3'b000,0,-1,0);
      // ports 0 and 1 together from reset
      add(1,1,3'b000,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b011,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b011,0,0,0,     1,3'b000,3'b000,1, 0,0);
      add(0,1,3'b011,1,0,0,     1,3'b001,3'b000,1, 0,0);
      add(0,1,3'b010,0,1,RD2,   0,3'b000,3'b001,1,-1,RD2);
      add(0,1,3'b010,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b010,0,0,0,     1,3'b000,3'b000,1, 1,0);
      add(0,1,3'b010,1,0,0,     1,3'b010,3'b000,1, 1,0);
      add(0,1,3'b000,1,0,0,     0,3'b000,3'b000,1,-1,0);
      add(0,1,3'b000,0,1,RD3,   0,3'b000,3'b010,1,-1,RD3);
      add(0,1,3'b000,0,0,0,     0,3'b000,3'b000,0,-1,0);
      // port 2 withdraws before grant; pointer must stay at 2
      add(0,1,3'b100,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b100,0,0,0,     1,3'b000,3'b000,1, 2,0);
      add(0,1,3'b000,1,0,0,     0,3'b000,3'b000,1, 2,0);
      add(0,1,3'b101,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b101,0,0,0,     1,3'b000,3'b000,1, 2,0);
      add(0,1,3'b101,1,0,0,     1,3'b100,3'b000,1, 2,0);
      // flush while waiting, response absorbed silently
      add(0,0,3'b001,0,0,0,     0,3'b000,3'b000,1,-1,0);
      add(0,0,3'b001,0,0,0,     0,3'b000,3'b000,1,-1,0);
      add(0,0,3'b001,0,0,0,     0,3'b000,3'b000,1,-1,0);
      add(0,0,3'b001,0,1,RD1,   0,3'b000,3'b000,1,-1,0);
      add(0,0,3'b001,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,0,3'b001,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b001,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b001,0,0,0,     1,3'b000,3'b000,1, 0,0);
      // async reset in Req with grant pending, then normal latency
      add(1,1,3'b001,1,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b001,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b001,0,0,0,     1,3'b000,3'b000,1, 0,0);
      add(0,1,3'b001,1,0,0,     1,3'b001,3'b000,1, 0,0);
      add(0,1,3'b000,0,1,RD2,   0,3'b000,3'b001,1,-1,RD2);
      add(0,1,3'b000,0,0,0,     0,3'b000,3'b000,0,-1,0);
      // flush in Req: no grant, late valid ignored
      add(0,1,3'b010,0,0,0,     0,3'b000,3'b000,0,-1,0);
      add(0,1,3'b010,0,0,0,     1,3'b000,3'b000,1, 1,0);
      add(0,0,3'b010,1,0,0,     0,3'b000,3'b000,1, 1,0);
      add(0,1,3'b000,0,1,RD3,   0,3'b000,3'b000,0,-1,0);

      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge clk);
         rst_n       = !vecs[r].rst;
         dm          = vecs[r].dm;
         bus.req_i   = vecs[r].req;
         bus.gnt_i   = vecs[r].gnt;
         bus.valid_i = vecs[r].vld;
         bus.rdata_i = vecs[r].rdata;
         #2;
         check($sformatf("vec%0d", r), obs(),
               {vecs[r].e_req, vecs[r].e_gnt, vecs[r].e_vld, vecs[r].e_busy,
                pay(vecs[r].e_port), vecs[r].e_rdata});
      end

      // all three ports requesting, downstream answers immediately
      do_reset();
      bus.req_i = 3'b111; bus.gnt_i = 1'b1; bus.valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #2;
         n_tests++;
         if ($countones(bus.gnt_o) > 1) begin
            n_fail++;
            $display("FAIL rr_onehot cycle %0d: gnt_o %b", c, bus.gnt_o);
         end
         for (int k = 0; k < N; k++) if (bus.gnt_o[k]) order.push_back(k);
      end
      n_tests++;
      if (order.size() < 6) begin
         n_fail++;
         $display("FAIL rr_count: got %0d grants expected at least 6", order.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (order[i] != i % N) begin
               n_fail++;
               $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % N);
            end
         end
      end

      // randomized traffic against the transaction-level model
      do_reset();
      bus.gnt_i = 1'b0; bus.valid_i = 1'b0;
      m_owner = -1; m_wait = 0; m_rr = 0; last_gnt = '0;
      for (int c = 0; c < 800; c++) begin
         logic        ereq;
         logic [2:0]  eg, ev;
         logic [138:0] ep;
         logic [63:0] er;
         logic [2:0]  rq;
         @(negedge clk);
         rq = bus.req_i;
         for (int k = 0; k < N; k++) begin
            if (last_gnt[k]) rq[k] = 1'b0;
            else if (rq[k]) begin
               if ($urandom_range(0, 29) == 0) rq[k] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               rq[k]      = 1'b1;
               p_addr[k]  = {$urandom, $urandom};
               p_we[k]    = 1'($urandom);
               p_wdata[k] = {$urandom, $urandom};
               p_be[k]    = 8'($urandom);
               p_size[k]  = 2'($urandom);
            end
         end
         bus.req_i   = rq;
         dm          = ($urandom_range(0, 19) != 0);
         bus.gnt_i   = ($urandom_range(0, 2) == 0);
         bus.valid_i = ($urandom_range(0, 2) == 0);
         bus.rdata_i = {$urandom, $urandom};
         #2;
         ereq = 0; eg = '0; ev = '0; ep = '0; er = '0;
         if (m_owner >= 0 && !m_wait) begin
            ep = pay(m_owner);
            if (dm && rq[m_owner[1:0]]) begin
               ereq = 1'b1;
               eg[m_owner[1:0]] = bus.gnt_i;
            end
         end else if (m_owner >= 0 && m_wait && bus.valid_i && dm) begin
            ev[m_owner[1:0]] = 1'b1;
            er = bus.rdata_i;
         end
         check($sformatf("rand%0d", c), obs(), {ereq, eg, ev, 1'(m_owner >= 0), ep, er});
         last_gnt = bus.gnt_o;
         if (m_owner < 0) begin
            if (dm && rq != 0) begin
               for (int off = 0; off < N; off++) begin
                  int p;
                  p = (m_rr + off) % N;
                  if (m_owner < 0 && rq[p[1:0]]) m_owner = p;
               end
               m_wait = 0;
            end
         end else if (!m_wait) begin
            if (!dm || !rq[m_owner[1:0]]) m_owner = -1;
            else if (bus.gnt_i) begin
               m_rr = (m_owner + 1) % N;
               m_wait = 1;
            end
         end else if (bus.valid_i) begin
            m_owner = -1;
            m_wait = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
